// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester identifiers and the read-latency counter width.
package mem_arb_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        ACCESS = S_ACCESS,
        WAIT   = S_WAIT,
        RESP   = S_RESP
    } state_t;

    // Requester identifiers, also the encoding of the owner output.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Wide enough for the largest legal memory latency (15).
    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals of the memory port arbiter.
// master: core + memory side (drives requests and mem_rdata).
// slave:  the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, busy, owner
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, busy, owner
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between the fetch and load/store requesters.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: on a simultaneous request, grant the
// port that did not win last time; otherwise data always beats fetch.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_owner,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    // Lone requests win outright; only a tie consults the policy.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (d_req && !i_req) begin
            grant_owner = OWN_D;
        end else if (d_req && i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
            // Data first so a stalled load/store never waits behind fetch.
            grant_owner = OWN_D;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and
// load/store. Serialises accesses, waits out MEM_LATENCY on reads and returns
// a one-cycle done pulse per transaction. Reset is synchronous, active-low.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY);

    state_t            state;
    logic [LAT_W-1:0]  cnt;
    logic              we_q;

    logic              grant_valid;
    logic              grant_owner;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    arb_pick u_pick (
        .i_req       (bus.i_req),
        .d_req       (bus.d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner  (bus.owner),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Route the winning requester's address/data/we toward the memory registers.
    always_comb begin
        sel_addr  = bus.i_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (grant_owner == OWN_D) begin
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            sel_we    = bus.d_we;
        end
    end

    // Transaction FSM; every output is a register updated on the state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
            bus.owner     <= OWN_I;
        end else begin
            // Strobes and done pulses last exactly one cycle.
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        // Strobes are loaded here so they are high during ACCESS.
                        bus.owner     <= grant_owner;
                        we_q          <= sel_we;
                        bus.mem_read  <= !sel_we;
                        bus.mem_write <= sel_we;
                        bus.mem_addr  <= {2'b00, sel_addr[ADDR_W-1:2]};
                        bus.mem_wdata <= sel_wdata;
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        // Stores need no read-back; finish next cycle.
                        bus.d_done <= (bus.owner == OWN_D);
                        bus.i_done <= (bus.owner == OWN_I);
                        state      <= RESP;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    // Counter about to hit zero: mem_rdata is valid this cycle.
                    if (cnt == LAT_W'(1)) begin
                        if (bus.owner == OWN_D) begin
                            bus.d_rdata <= bus.mem_rdata;
                            bus.d_done  <= 1'b1;
                        end else begin
                            bus.i_rdata <= bus.mem_rdata;
                            bus.i_done  <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a latency-1 instance driven from a vector
// table with a done-pulse scoreboard, plus a latency-3 instance for the
// long-wait and mid-transaction reset sequences.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
    mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(1)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(3)) dut3 (
        .clk (clk), .rst (rst3), .bus (bus3)
    );

    function automatic logic [31:0] pat(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
    endfunction

    // Latency-1 memory: preloads while its arbiter is in reset.
    logic [31:0] mem1 [0:63];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem1[i] <= pat(i);
            rd1 <= 32'h0;
        end else begin
            if (bus.mem_write) mem1[bus.mem_addr[5:0]] <= bus.mem_wdata;
            rd1 <= bus.mem_read ? mem1[bus.mem_addr[5:0]] : 32'hBAD0_0BAD;
        end
    end
    assign bus.mem_rdata = rd1;

    // Latency-3 memory: read data walks a three-stage delay line.
    logic [31:0] mem3 [0:63];
    logic [31:0] p0, p1, p2;
    always @(posedge clk) begin
        if (!rst3) begin
            for (int i = 0; i < 64; i++) mem3[i] <= pat(i);
            p0 <= 32'h0; p1 <= 32'h0; p2 <= 32'h0;
        end else begin
            if (bus3.mem_write) mem3[bus3.mem_addr[5:0]] <= bus3.mem_wdata;
            p0 <= bus3.mem_read ? mem3[bus3.mem_addr[5:0]] : 32'hBAD0_0BAD;
            p1 <= p0;
            p2 <= p1;
        end
    end
    assign bus3.mem_rdata = p2;

    int n_vec = 0;
    int n_err = 0;
    int strobe_viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Both strobes together is never legal on either instance.
    always @(negedge clk) begin
        if ((bus.mem_read === 1'b1 && bus.mem_write === 1'b1) ||
            (bus3.mem_read === 1'b1 && bus3.mem_write === 1'b1))
            strobe_viol++;
    end

    typedef struct {
        logic        port;      // 0 fetch, 1 load/store
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_maddr;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic        we;
        int          lat;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_i = 32'h0;
    logic [31:0] last_d = 32'h0;

    // Issue one transaction from IDLE and check it through to its done pulse.
    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   got;
        e.port = v.port; e.we = v.we; e.lat = v.exp_lat; e.rdata = v.exp_rdata;
        sb.push_back(e);
        bus.i_addr  = v.addr;
        bus.d_addr  = v.addr;
        bus.d_we    = v.we;
        bus.d_wdata = v.wdata;
        if (v.port) bus.d_req = 1'b1; else bus.i_req = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                chk("access_read",  bus.mem_read,  !v.we);
                chk("access_write", bus.mem_write, v.we);
                chk("access_addr",  bus.mem_addr,  v.exp_maddr);
                chk("access_owner", bus.owner,     v.port);
                chk("access_busy",  bus.busy,      1'b1);
                if (v.we) chk("access_wdata", bus.mem_wdata, v.wdata);
            end
            if (bus.i_done || bus.d_done) begin
                got = 1'b1;
                e = sb.pop_front();
                chk("done_d",   bus.d_done, e.port);
                chk("done_i",   bus.i_done, !e.port);
                chk("done_lat", 32'(k),     32'(e.lat));
                if (!e.we) begin
                    if (e.port) last_d = e.rdata; else last_i = e.rdata;
                end
                chk("d_rdata", bus.d_rdata, last_d);
                chk("i_rdata", bus.i_rdata, last_i);
            end
        end
        if (!got) chk("done_timeout", 32'h0, 32'h1);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 1'b0);
    endtask

    vec_t vt [12];
    logic seq [4];
    logic exp_seq [4];

    initial begin
        // Watchdog: the whole run is a few hundred cycles.
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int k_d, k_i;
        vt[0]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0008, 2, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0008, 3, 32'h1234_5678};
        vt[2]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0004, 3, 32'hDEAD_BEEF};
        vt[3]  = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h0000_0011, 2, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         32'h0000_0011, 3, 32'hCAFE_F00D};
        vt[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0004, 3, 32'hDEAD_BEEF};
        vt[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 3, 32'hA5A5_0000};
        vt[7]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         32'h0000_003F, 3, 32'hA5A5_003F};
        vt[8]  = '{1'b1, 1'b1, 32'h0000_004B, 32'h0BAD_CAFE, 32'h0000_0012, 2, 32'h0};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,         32'h0000_0012, 3, 32'h0BAD_CAFE};
        vt[10] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0008, 3, 32'h1234_5678};
        vt[11] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0,         32'h2000_0004, 3, 32'hDEAD_BEEF};

        rst = 1'b0; rst3 = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_wdata = 32'h0;
        bus3.i_req = 1'b0; bus3.i_addr = 32'h0;
        bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = 32'h0; bus3.d_wdata = 32'h0;

        // Reset held with both requests pending: everything stays quiet.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_done",    bus.i_done,    1'b0);
        chk("rst_d_done",    bus.d_done,    1'b0);
        chk("rst_i_rdata",   bus.i_rdata,   32'h0);
        chk("rst_d_rdata",   bus.d_rdata,   32'h0);
        chk("rst_mem_read",  bus.mem_read,  1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_owner",     bus.owner,     1'b0);
        rst = 1'b1; rst3 = 1'b1;
        @(posedge clk); #1;
        chk("rel_busy",  bus.busy,     1'b1);
        chk("rel_read",  bus.mem_read, 1'b1);
        chk("rel_owner", bus.owner,    1'b1);
        chk("rel_addr",  bus.mem_addr, 32'h8);
        // Drain the two pending requests: data (k=2 from here), then fetch.
        for (int c = 0; c < 30 && (bus.i_req || bus.d_req); c++) begin
            @(posedge clk); #1;
            if (bus.d_done) begin
                chk("rel_d_rdata", bus.d_rdata, 32'hA5A5_0008);
                bus.d_req = 1'b0;
            end
            if (bus.i_done) begin
                chk("rel_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
                bus.i_req = 1'b0;
            end
        end
        chk("rel_drain", {bus.i_req, bus.d_req}, 2'b00);
        last_d = 32'hA5A5_0008;
        last_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(vt[i]);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        // Contention after a fetch: data wins, fetch follows from next IDLE.
        bus.i_addr = 32'h10; bus.d_addr = 32'h20; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        k_d = 0; k_i = 0;
        for (int k = 1; k <= 30 && (bus.i_req || bus.d_req); k++) begin
            @(posedge clk); #1;
            if (bus.d_done) begin k_d = k; chk("cont_d_rdata", bus.d_rdata, 32'h1234_5678); bus.d_req = 1'b0; end
            if (bus.i_done) begin k_i = k; chk("cont_i_rdata", bus.i_rdata, 32'hDEAD_BEEF); bus.i_req = 1'b0; end
        end
        chk("cont_d_lat", 32'(k_d), 32'd3);
        chk("cont_i_lat", 32'(k_i), 32'd7);
        @(posedge clk); #1;

        // Both requests held across several transactions.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
`else
        exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1; exp_seq[3] = 1'b1;
`endif
        n = 0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int c = 0; c < 60 && (bus.i_req || bus.d_req); c++) begin
            @(posedge clk); #1;
            if (bus.i_done || bus.d_done) begin
                if (n < 4) seq[n] = bus.owner;
                n++;
                if (n >= 4) bus.d_req = 1'b0;
                if (n >= 4 && bus.i_done) bus.i_req = 1'b0;
            end
        end
        chk("hold_drain", {bus.i_req, bus.d_req}, 2'b00);
        for (int i = 0; i < 4; i++) chk($sformatf("hold_owner%0d", i), seq[i], exp_seq[i]);
        @(posedge clk); #1;
        chk("hold_last_owner", bus.owner, 1'b0);

        // Latency-3 load: done five cycles after the request is sampled.
        k_d = 0;
        bus3.d_addr = 32'h20; bus3.d_we = 1'b0; bus3.d_req = 1'b1;
        for (int k = 1; k <= 20 && k_d == 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("l3_read", bus3.mem_read, 1'b1);
            if (bus3.d_done) begin
                k_d = k;
                chk("l3_rdata", bus3.d_rdata, 32'hA5A5_0008);
                bus3.d_req = 1'b0;
            end
        end
        chk("l3_lat", 32'(k_d), 32'd5);
        @(posedge clk); #1;

        // Reset in the middle of WAIT abandons the load silently.
        bus3.d_addr = 32'h24; bus3.d_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy_wait", bus3.busy, 1'b1);
        rst3 = 1'b0; bus3.d_req = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy",    bus3.busy,    1'b0);
        chk("mid_cnt",     dut3.cnt,     32'h0);
        chk("mid_d_rdata", bus3.d_rdata, 32'h0);
        rst3 = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus3.d_done || bus3.i_done || bus3.busy) n++;
        end
        chk("mid_no_done", 32'(n), 32'h0);

        chk("strobe_excl", 32'(strobe_viol), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous-read data memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write). This allows a unified von Neumann memory behind the PC/fetch path and the load/store path.
- Sits between the core datapath and the memory.
- Serialises accesses, sequences the memory's read latency, and returns data with a one-cycle done pulse per transaction.

Parameters:
- DATA_W, 32, data width of all data ports.
- ADDR_W, 32, byte-address width of requester and memory address ports.
- MEM_LATENCY, 1, cycles from the memory sampling mem_read to valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset; asserted when rst==0, sampled on the rising edge of clk.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  ADDR_W  fetch byte address.
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched word; holds until the next fetch completes.
- d_req  in  1  load/store request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  load/store byte address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse: load/store complete.
- d_rdata  out  DATA_W  load data; holds until the next load completes.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word address = {2'b00, addr[ADDR_W-1:2]}.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.
- owner  out  1  current or last grantee: 0 = fetch, 1 = data.

Behaviour:
- Reset: state goes to IDLE. All outputs are driven to 0, including i_rdata, d_rdata, and owner. The latency counter clears.
- Reset mid-transaction: the transaction is abandoned and no done pulse is issued. A write strobe already presented to memory is not recalled.
- States:
  - IDLE: if any req is high, pick a winner and register its address, write data, we flag and owner, then go to ACCESS. The fetch port's we is always 0. If no req is high, stay in IDLE.
  - ACCESS: exactly one cycle. Drive mem_read = !we or mem_write = we, plus mem_addr and mem_wdata, all registered. For a read, load counter = MEM_LATENCY and go to WAIT. For a write, go to RESP.
  - WAIT: decrement the counter. When it reaches 0 (the cycle where mem_rdata is valid), capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP: pulse the owner's done for one cycle, then go to IDLE.
- Timing, with req sampled in cycle T:
  - Store: done in T+2.
  - Load/fetch: done in T+2+MEM_LATENCY, so T+3 at the default latency.
- Only one of mem_read/mem_write is ever high. Both are low outside ACCESS.
- mem_addr and mem_wdata hold their values from ACCESS until the next ACCESS.
- Requests arriving while busy are not sampled. The requester keeps req high, and it is considered at the next IDLE.
- Req high in the cycle after done is a new request (back-to-back transactions are allowed).
- Arbitration when both requests are high in IDLE: fixed priority, data over fetch. This prevents a stalled load/store from deadlocking behind fetch.
- A request dropped before its done pulse is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant the port not granted last, using the registered owner. Single requests are granted immediately, as in the default.
- Undefined: fixed data-over-fetch priority.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding IDLE/ACCESS/WAIT/RESP (2-bit localparams);
  - OWN_I = 1'b0 and OWN_D = 1'b1;
  - counter width LAT_W = 4.
- One sub-module, arb_pick: combinational winner selection from i_req, d_req and the last owner, plus the round-robin option. Everything else lives in the top FSM.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both reqs high -> all outputs 0, busy 0, no mem strobes. Release -> ACCESS the cycle after the next edge.
- Lone fetch: i_addr=0x0000_0010, memory returns 0xDEAD_BEEF -> mem_read high one cycle with mem_addr=4. i_done pulses at T+3 with i_rdata=0xDEAD_BEEF. d_done stays 0.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0x1234_5678 -> mem_write one cycle with mem_addr=8, d_done at T+2. Then a load of 0x20 -> d_rdata=0x1234_5678 at T+3.
- Contention: i_req and d_req rise together -> data served first, then fetch starts from the next IDLE. Under MEM_ARB_ROUND_ROBIN_EN with both held across 4 transactions, owner alternates 1,0,1,0.
- MEM_LATENCY=3 load -> done at T+5. Mid-WAIT rst=0 -> no done, state IDLE, counter 0.
